// File: rtl/vga_ch_arbiter_pkg.sv
// Shared types and constants for the VGA character-buffer arbiter.
// Holds the buffer base address, default requester count and FSM state type.
package vga_ch_arbiter_pkg;

  localparam logic [31:0] VGA_PX_BASE     = 32'h0800_0000;
  localparam int          VGA_ARB_NUM_REQ = 4;

  typedef enum logic {
    ARB   = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/vga_ch_arbiter_rr_pick.sv
// Combinational round-robin picker: first pending index at or after ptr,
// wrapping explicitly so non-power-of-two requester counts stay in range.
module vga_ch_arbiter_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] pending,
  input  logic [IDX_W-1:0]   ptr,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);

  int               cand;
  logic [IDX_W-1:0] cand_idx;

  always_comb begin
    found    = 1'b0;
    idx      = '0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(ptr) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!found && pending[cand_idx]) begin
        found = 1'b1;
        idx   = cand_idx;
      end
    end
  end

endmodule

// File: rtl/vga_ch_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM master into the VGA character
// buffer; one single-beat read or write is forwarded per grant.
module vga_ch_arbiter
  import vga_ch_arbiter_pkg::*;
#(
  parameter int NUM_REQ = VGA_ARB_NUM_REQ,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      dbg_rst_n,
  input  logic [NUM_REQ*ADDR_W-1:0] req_address,
  input  logic [NUM_REQ-1:0]        req_read,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*DATA_W-1:0] req_writedata,
  output logic [DATA_W-1:0]         req_readdata,
  output logic [NUM_REQ-1:0]        req_waitrequest,
  output logic [ADDR_W-1:0]         vga_ch_address,
  output logic                      vga_ch_read,
  output logic                      vga_ch_write,
  output logic [DATA_W-1:0]         vga_ch_writedata,
  input  logic [DATA_W-1:0]         vga_ch_readdata,
  input  logic                      vga_ch_waitrequest,
  output logic [NUM_REQ-1:0]        grant_onehot
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_t       state;
  logic [IDX_W-1:0] grant_idx;
  logic [IDX_W-1:0] rr_ptr;

  logic [ADDR_W-1:0] addr_a  [NUM_REQ];
  logic [DATA_W-1:0] wdata_a [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addr_a[i]  = req_address[i*ADDR_W +: ADDR_W];
    assign wdata_a[i] = req_writedata[i*DATA_W +: DATA_W];
  end

  logic [NUM_REQ-1:0] pending;
  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;

  assign pending = req_read | req_write;

  vga_ch_arbiter_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .pending (pending),
    .ptr     (rr_ptr),
    .found   (pick_found),
    .idx     (pick_idx)
  );

  // Read+write together is illegal; write wins and read is suppressed.
  logic             g_wr;
  logic             g_rd;
  logic [IDX_W-1:0] next_ptr;

  assign g_wr     = req_write[grant_idx];
  assign g_rd     = req_read[grant_idx] & ~g_wr;
  assign next_ptr = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ARB;
      grant_idx <= '0;
      rr_ptr    <= '0;
    end else if (!dbg_rst_n) begin
      state     <= ARB;
      grant_idx <= '0;
      rr_ptr    <= '0;
    end else begin
      case (state)
        ARB: begin
          if (pick_found) begin
            grant_idx <= pick_idx;
            state     <= GRANT;
          end
        end
        GRANT: begin
          // Dropped strobes abort the grant without moving the pointer.
          if (!g_rd && !g_wr) begin
            state <= ARB;
          end else if (!vga_ch_waitrequest) begin
            state  <= ARB;
            rr_ptr <= next_ptr;
          end
        end
        default: state <= ARB;
      endcase
    end
  end

  always_comb begin
    vga_ch_address   = ADDR_W'(VGA_PX_BASE);
    vga_ch_writedata = '0;
    vga_ch_read      = 1'b0;
    vga_ch_write     = 1'b0;
    req_waitrequest  = '1;
    req_readdata     = '0;
    grant_onehot     = '0;
    if (state == GRANT) begin
      vga_ch_address             = addr_a[grant_idx];
      vga_ch_writedata           = wdata_a[grant_idx];
      vga_ch_read                = g_rd;
      vga_ch_write               = g_wr;
      req_waitrequest[grant_idx] = vga_ch_waitrequest;
      req_readdata               = vga_ch_readdata;
      grant_onehot[grant_idx]    = 1'b1;
    end
  end

endmodule

// File: tb/tb_vga_ch_arbiter.sv
// Directed bench for vga_ch_arbiter: expected master beats are queued as
// requests are issued and popped by a monitor as beats complete.
module tb_vga_ch_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 16;
  localparam int EW = 58;
  localparam logic [31:0] BASE = vga_ch_arbiter_pkg::VGA_PX_BASE;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            dbg_rst_n;
  logic [N*AW-1:0] req_address;
  logic [N-1:0]    req_read;
  logic [N-1:0]    req_write;
  logic [N*DW-1:0] req_writedata;
  logic [DW-1:0]   req_readdata;
  logic [N-1:0]    req_waitrequest;
  logic [AW-1:0]   vga_ch_address;
  logic            vga_ch_read;
  logic            vga_ch_write;
  logic [DW-1:0]   vga_ch_writedata;
  logic [DW-1:0]   vga_ch_readdata;
  logic            vga_ch_waitrequest;
  logic [N-1:0]    grant_onehot;

  logic [EW-1:0] exp_q[$];
  int            beat_cyc_q[$];
  logic [EW-1:0] mon_exp;
  int            n_checks  = 0;
  int            n_fail    = 0;
  int            wr_hi_cnt = 0;
  int            cyc       = 0;
  bit            mon_en    = 1'b0;

  vga_ch_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .dbg_rst_n          (dbg_rst_n),
    .req_address        (req_address),
    .req_read           (req_read),
    .req_write          (req_write),
    .req_writedata      (req_writedata),
    .req_readdata       (req_readdata),
    .req_waitrequest    (req_waitrequest),
    .vga_ch_address     (vga_ch_address),
    .vga_ch_read        (vga_ch_read),
    .vga_ch_write       (vga_ch_write),
    .vga_ch_writedata   (vga_ch_writedata),
    .vga_ch_readdata    (vga_ch_readdata),
    .vga_ch_waitrequest (vga_ch_waitrequest),
    .grant_onehot       (grant_onehot)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [EW-1:0] mk_beat(input int i, input bit rd, input bit wr,
                                            input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic [7:0] oh;
    oh    = '0;
    oh[i] = 1'b1;
    return {oh, rd & ~wr, wr, a, wr ? d : 16'h0};
  endfunction

  // driver tasks
  task automatic set_req(input int i, input bit rd, input bit wr,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_read[i]               = rd;
    req_write[i]              = wr;
    req_address[i*AW +: AW]   = a;
    req_writedata[i*DW +: DW] = d;
  endtask

  task automatic issue(input int i, input bit rd, input bit wr,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    set_req(i, rd, wr, a, d);
    exp_q.push_back(mk_beat(i, rd, wr, a, d));
  endtask

  // One cycle of requester behaviour: completed requesters drop their strobes.
  task automatic step_cycle(input logic [N-1:0] sticky, output logic [N-1:0] done);
    @(negedge clk);
    done = (req_read | req_write) & ~req_waitrequest;
    for (int i = 0; i < N; i++)
      if (done[i] && req_read[i] && !req_write[i]) chk("rd_data", req_readdata, vga_ch_readdata);
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (done[i] && !sticky[i]) begin
        req_read[i]  = 1'b0;
        req_write[i] = 1'b0;
      end
  endtask

  task automatic run_until_idle(input string tag);
    logic [N-1:0] d;
    int k;
    k = 0;
    while ((req_read | req_write) != '0 && k < 60) begin
      step_cycle('0, d);
      k++;
    end
    chk(tag, req_read | req_write, 0);
  endtask

  task automatic wait_grant(input string tag);
    int k;
    k = 0;
    @(negedge clk);
    while (grant_onehot == '0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk(tag, grant_onehot != '0, 1);
  endtask

  // scoreboard monitor on the master side
  always @(negedge clk) begin
    if (mon_en) begin
      chk("wait_others", req_waitrequest | grant_onehot, 4'hF);
      if (vga_ch_write) wr_hi_cnt++;
      if ((vga_ch_read || vga_ch_write) && !vga_ch_waitrequest) begin
        beat_cyc_q.push_back(cyc);
        chk("beat_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          mon_exp = exp_q.pop_front();
          chk("beat", {4'b0, grant_onehot, vga_ch_read, vga_ch_write, vga_ch_address,
                       vga_ch_write ? vga_ch_writedata : 16'h0}, mon_exp);
        end
      end
    end
  end

  initial begin
    logic [N-1:0] d;
    int k, wr0, nb0, sz;
    reset_n            = 1'b0;
    dbg_rst_n          = 1'b1;
    req_address        = '0;
    req_read           = '0;
    req_write          = '0;
    req_writedata      = '0;
    vga_ch_readdata    = 16'h0;
    vga_ch_waitrequest = 1'b0;
    mon_en             = 1'b1;

    @(negedge clk);
    chk("rst_wait", req_waitrequest, 4'hF);
    chk("rst_rd", vga_ch_read, 0);
    chk("rst_wr", vga_ch_write, 0);
    chk("rst_addr", vga_ch_address, BASE);
    chk("rst_wdata", vga_ch_writedata, 0);
    chk("rst_grant", grant_onehot, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // single write from requester 1
    wr0 = wr_hi_cnt;
    issue(1, 0, 1, BASE | (32'd2 << 7) | 32'd4, 16'h0041);
    run_until_idle("single_idle");
    chk("single_wr_len", wr_hi_cnt - wr0, 1);

    // pointer now 2: requester 2 must win over 0
    issue(2, 0, 1, BASE | 32'h22, 16'h1222);
    issue(0, 0, 1, BASE | 32'h20, 16'h1000);
    run_until_idle("ptr2_idle");

    // read from requester 3; pointer wraps back to 0
    vga_ch_readdata = 16'h0033;
    issue(3, 1, 0, BASE | 32'h33, 16'h0);
    run_until_idle("read_idle");

    // contention 0,2,3 from pointer 0
    issue(0, 0, 1, BASE | 32'h100, 16'hA000);
    issue(2, 0, 1, BASE | 32'h102, 16'hA002);
    issue(3, 0, 1, BASE | 32'h103, 16'hA003);
    run_until_idle("cont_idle");
    sz = beat_cyc_q.size();
    chk("cont_gap_a", beat_cyc_q[sz-2] - beat_cyc_q[sz-3], 2);
    chk("cont_gap_b", beat_cyc_q[sz-1] - beat_cyc_q[sz-2], 2);

    // back-pressure: 5 stalled cycles, completes on the 6th
    vga_ch_waitrequest = 1'b1;
    wr0 = wr_hi_cnt;
    issue(2, 0, 1, BASE | 32'h2A5, 16'h5A5A);
    wait_grant("bp_grant");
    for (int j = 0; j < 5; j++) begin
      if (j > 0) @(negedge clk);
      chk("bp_wr", vga_ch_write, 1);
      chk("bp_addr", vga_ch_address, BASE | 32'h2A5);
      chk("bp_data", vga_ch_writedata, 16'h5A5A);
    end
    @(posedge clk);
    #1 vga_ch_waitrequest = 1'b0;
    run_until_idle("bp_idle");
    chk("bp_wr_len", wr_hi_cnt - wr0, 6);

    // read and write together: write forwarded, read forced low
    issue(1, 1, 1, BASE | 32'h311, 16'h0B0B);
    run_until_idle("rdwr_idle");

    // fairness: requester 0 re-requests continuously
    issue(0, 0, 1, BASE | 32'h400, 16'hF000);
    k = 0;
    d = '0;
    while (!d[0] && k < 20) begin step_cycle(4'b0001, d); k++; end
    chk("fair_first", d[0], 1);
    issue(1, 0, 1, BASE | 32'h401, 16'hF001);
    nb0 = beat_cyc_q.size();
    k = 0;
    d = '0;
    while (!d[1] && k < 20) begin step_cycle(4'b0001, d); k++; end
    set_req(0, 0, 0, '0, '0);
    chk("fair_bound", (beat_cyc_q.size() - nb0) <= 2, 1);
    run_until_idle("fair_idle");

    // asynchronous reset during a stalled grant
    vga_ch_waitrequest = 1'b1;
    set_req(2, 0, 1, BASE | 32'h502, 16'hC002);
    wait_grant("arst_grant");
    #1 reset_n = 1'b0;
    #1;
    chk("arst_wr", vga_ch_write, 0);
    chk("arst_wait", req_waitrequest, 4'hF);
    chk("arst_grant", grant_onehot, 0);
    set_req(1, 0, 1, BASE | 32'h501, 16'hC001);
    set_req(3, 0, 1, BASE | 32'h503, 16'hC003);
    repeat (2) @(posedge clk);
    #1;
    vga_ch_waitrequest = 1'b0;
    reset_n = 1'b1;
    exp_q.push_back(mk_beat(1, 0, 1, BASE | 32'h501, 16'hC001));
    exp_q.push_back(mk_beat(2, 0, 1, BASE | 32'h502, 16'hC002));
    exp_q.push_back(mk_beat(3, 0, 1, BASE | 32'h503, 16'hC003));
    run_until_idle("arst_idle");

    // synchronous soft reset during a stalled grant
    vga_ch_waitrequest = 1'b1;
    set_req(2, 0, 1, BASE | 32'h602, 16'hD002);
    wait_grant("dbg_grant");
    #1 dbg_rst_n = 1'b0;
    #1 chk("dbg_sync_hold", grant_onehot, 4'b0100);
    @(posedge clk);
    #1;
    chk("dbg_wr", vga_ch_write, 0);
    chk("dbg_grant", grant_onehot, 0);
    set_req(1, 0, 1, BASE | 32'h601, 16'hD001);
    @(posedge clk);
    #1;
    dbg_rst_n = 1'b1;
    vga_ch_waitrequest = 1'b0;
    exp_q.push_back(mk_beat(1, 0, 1, BASE | 32'h601, 16'hD001));
    exp_q.push_back(mk_beat(2, 0, 1, BASE | 32'h602, 16'hD002));
    run_until_idle("dbg_idle");

    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_ch_arbiter.md
Name: vga_ch_arbiter

Overview:
- Shares the single Avalon-MM master into the VGA character buffer among NUM_REQ on-chip requesters, e.g. score display, game-over banner, title text, clear-screen.
- Each requester sees its own Avalon-MM slave-like port, with waitrequest back-pressure.
- The arbiter grants one requester at a time, round-robin, and forwards exactly one single-beat read or write per grant.
- It sits between the game-logic text writers and the `vga_master` conduit on the Qsys interconnect.

Parameters:
- NUM_REQ, 4: number of requester ports (2..8).
- ADDR_W, 32: address width, per requester and on the master.
- DATA_W, 16: data width, matching the character buffer.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- dbg_rst_n  in  1  conduit; synchronous active-low soft reset, same effect as reset_n
- req_address  in  NUM_REQ*ADDR_W  packed per-requester address; slice i = bits [i*ADDR_W +: ADDR_W]
- req_read  in  NUM_REQ  per-requester read strobe
- req_write  in  NUM_REQ  per-requester write strobe
- req_writedata  in  NUM_REQ*DATA_W  packed per-requester write data
- req_readdata  out  DATA_W  broadcast readdata; valid only to the requester whose waitrequest is low
- req_waitrequest  out  NUM_REQ  per-requester waitrequest
- vga_ch_address  out  ADDR_W  master address
- vga_ch_read  out  1  master read
- vga_ch_write  out  1  master write
- vga_ch_writedata  out  DATA_W  master write data
- vga_ch_readdata  in  DATA_W  master read data
- vga_ch_waitrequest  in  1  master waitrequest
- grant_onehot  out  NUM_REQ  current grant, for debug LEDs

Behaviour:
- State machine has two states, ARB and GRANT. Registers are state, grant_idx and rr_ptr.
- Reset (reset_n low asynchronously, or dbg_rst_n low at a clock edge):
  - state=ARB, grant_idx=0, rr_ptr=0.
  - Outputs settle to: all req_waitrequest=1, vga_ch_read=0, vga_ch_write=0, vga_ch_address=`VGA_PX_BASE, vga_ch_writedata=0, grant_onehot=0.
- In ARB:
  - A requester is pending when req_read[i] | req_write[i].
  - Search starts at rr_ptr and wraps modulo NUM_REQ. The first pending index is latched into grant_idx and state goes to GRANT.
  - If nothing is pending, stay in ARB.
  - Master strobes are 0 in ARB.
- In GRANT:
  - Master outputs are driven combinationally from slice grant_idx: address, writedata, read, write.
  - req_waitrequest[grant_idx] = vga_ch_waitrequest; every other bit = 1.
  - req_readdata = vga_ch_readdata.
  - grant_onehot = 1 << grant_idx.
- Completion: in GRANT, when vga_ch_waitrequest=0 and (read|write) is asserted, the beat completes that cycle. Then state goes to ARB and rr_ptr = (grant_idx+1) mod NUM_REQ.
- Latency: at least 2 cycles from request to completion — 1 arbitration cycle plus ≥1 GRANT cycle. Minimum period is 2 cycles per beat; this is an accepted bubble.
- Abort: if the granted requester drops both read and write while in GRANT, return to ARB with no beat issued and leave rr_ptr unchanged.
- Protocol rules for requesters:
  - Hold address, data and strobes stable while their waitrequest=1.
  - Read and write asserted together is illegal. The arbiter forwards write=1 and forces read=0.
- Fairness: a requester that re-asserts immediately after completing goes behind every other pending requester, so its wait is bounded at NUM_REQ grants.
- Simultaneous events:
  - A new request arriving during GRANT is only considered at the next ARB.
  - Reset during GRANT drops the in-flight beat and forces master strobes to 0 immediately. This is acceptable because the character buffer tolerates aborted single beats.
- Width: NUM_REQ that is not a power of 2 wraps explicitly, never via a truncated counter.

Decomposition:
- snake_fpga.svh already provides `VGA_PX_BASE. Add there:
  - the arb_state_t typedef (ARB, GRANT);
  - `VGA_ARB_NUM_REQ, the default requester count.
- Sub-module rr_pick: purely combinational.
  - Inputs: pending[NUM_REQ], ptr.
  - Outputs: found, idx.
  - Instantiated once.

Test Plan:
- Single write: req1 writes addr=`VGA_PX_BASE|(2<<7)|4, data=0x41, master waitrequest=0 → vga_ch_write high exactly one cycle in GRANT with those values, req_waitrequest[1] low that cycle, rr_ptr=2.
- Contention: req0, req2 and req3 all assert writes in the same cycle from rr_ptr=0 → master beats in order 0,2,3, each 2 cycles apart; non-granted waitrequest bits stay 1 throughout.
- Back-pressure: granted write while master waitrequest is held high 5 cycles → master signals stable 5 cycles, completes on cycle 6, no duplicate beat.
- Read: req3 reads, master returns 0x0033 with waitrequest=0 → req_readdata=0x0033 while req_waitrequest[3]=0.
- Fairness: req0 continuously re-requests while req1 requests once → req1 is granted no later than the second grant after its assertion.
- Reset mid-grant: assert reset_n=0 during a stalled GRANT → vga_ch_write=0 and all waitrequest=1 immediately. After release, state=ARB, rr_ptr=0, and pending requests are re-arbitrated from index 0.
